// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction codes, ALU and
// condition function codes, and the condition-code register layout.
`default_nettype none

package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   localparam logic [3:0] C_ALWAYS = 4'h0;
   localparam logic [3:0] C_LE     = 4'h1;
   localparam logic [3:0] C_L      = 4'h2;
   localparam logic [3:0] C_E      = 4'h3;
   localparam logic [3:0] C_NE     = 4'h4;
   localparam logic [3:0] C_GE     = 4'h5;
   localparam logic [3:0] C_G      = 4'h6;

   typedef enum logic [1:0] {
      FN_ADD = 2'd0,
      FN_SUB = 2'd1,
      FN_AND = 2'd2,
      FN_XOR = 2'd3
   } alu_fn_t;

   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_t;

   localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

   function automatic logic opq_ifun_ok(input logic [3:0] ifun);
      return ifun <= ALU_XOR;
   endfunction

endpackage

`default_nettype wire

// File: rtl/execute_stage_alu.sv
// 64-bit Add/Sub/And/Xor units and the execute-stage ALU that muxes between
// them and derives the signed-overflow flag.
`default_nettype none

module add_unit #(
   parameter int W = 64
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);
   assign y_o = a_i + b_i;
endmodule

module sub_unit #(
   parameter int W = 64
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);
   assign y_o = a_i - b_i;
endmodule

module and_unit #(
   parameter int W = 64
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);
   assign y_o = a_i & b_i;
endmodule

module xor_unit #(
   parameter int W = 64
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);
   assign y_o = a_i ^ b_i;
endmodule

module execute_stage_alu
   import y86_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  alu_fn_t      fn_i,
   output logic [W-1:0] res_o,
   output logic         of_o
);

   logic [W-1:0] add_y;
   logic [W-1:0] sub_y;
   logic [W-1:0] and_y;
   logic [W-1:0] xor_y;

   // Y86 ordering: every operation is b OP a (valB - valA for subq).
   add_unit #(.W(W)) u_add (.a_i(b_i), .b_i(a_i), .y_o(add_y));
   sub_unit #(.W(W)) u_sub (.a_i(b_i), .b_i(a_i), .y_o(sub_y));
   and_unit #(.W(W)) u_and (.a_i(b_i), .b_i(a_i), .y_o(and_y));
   xor_unit #(.W(W)) u_xor (.a_i(b_i), .b_i(a_i), .y_o(xor_y));

   always_comb begin
      res_o = add_y;
      of_o  = 1'b0;
      case (fn_i)
         FN_ADD: begin
            res_o = add_y;
            of_o  = (a_i[W-1] == b_i[W-1]) && (add_y[W-1] != b_i[W-1]);
         end
         FN_SUB: begin
            res_o = sub_y;
            of_o  = (a_i[W-1] != b_i[W-1]) && (sub_y[W-1] != b_i[W-1]);
         end
         FN_AND: res_o = and_y;
         FN_XOR: res_o = xor_y;
         default: begin
            res_o = add_y;
            of_o  = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/execute_stage_cond_eval.sv
// Combinational evaluation of the Y86 jXX/cmovXX condition from ZF/SF/OF.
`default_nettype none

module cond_eval
   import y86_pkg::*;
(
   input  logic [3:0] ifun_i,
   input  logic       zf_i,
   input  logic       sf_i,
   input  logic       of_i,
   output logic       cnd_o
);

   logic lt;

   assign lt = sf_i ^ of_i;

   always_comb begin
      cnd_o = 1'b0;
      case (ifun_i)
         C_ALWAYS: cnd_o = 1'b1;
         C_LE:     cnd_o = lt | zf_i;
         C_L:      cnd_o = lt;
         C_E:      cnd_o = zf_i;
         C_NE:     cnd_o = ~zf_i;
         C_GE:     cnd_o = ~lt;
         C_G:      cnd_o = ~lt & ~zf_i;
         default:  cnd_o = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU operand/function select, registered result with a
// single-entry valid/ready output buffer, condition codes and Cnd evaluation.
`default_nettype none

module execute_stage
   import y86_pkg::*;
#(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   icode,
   input  logic [3:0]   ifun,
   input  logic [W-1:0] valA,
   input  logic [W-1:0] valB,
   input  logic [W-1:0] valC,
   input  logic         set_cc,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [3:0]   out_icode,
   output logic [W-1:0] out_valE,
   output logic [W-1:0] out_valA,
   output logic         out_cnd,
   output logic         out_err,
   output logic         cc_zf,
   output logic         cc_sf,
   output logic         cc_of
);

   localparam logic [W-1:0] C_EIGHT     = W'(8);
   localparam logic [W-1:0] C_MINUS_EIGHT = ~C_EIGHT + W'(1);

   logic         out_valid_q, out_valid_d;
   logic [3:0]   out_icode_q, out_icode_d;
   logic [W-1:0] out_valE_q, out_valE_d;
   logic [W-1:0] out_valA_q, out_valA_d;
   logic         out_cnd_q, out_cnd_d;
   logic         out_err_q, out_err_d;
   cc_t          cc_q, cc_d;

   logic         accept;
   logic         is_opq;
   logic         ifun_ok;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   alu_fn_t      alu_fn;
   logic [W-1:0] alu_res;
   logic         alu_of;
   logic         cnd;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   assign is_opq   = (icode == I_OPQ);
   assign ifun_ok  = opq_ifun_ok(ifun);

   // Operand select; instructions with no result leave both inputs at zero.
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_fn = FN_ADD;
      case (icode)
         I_RRMOVQ: alu_a = valA;
         I_IRMOVQ: alu_a = valC;
         I_RMMOVQ, I_MRMOVQ: begin
            alu_a = valC;
            alu_b = valB;
         end
         I_OPQ: begin
            if (ifun_ok) begin
               alu_a  = valA;
               alu_b  = valB;
               alu_fn = alu_fn_t'(ifun[1:0]);
            end
         end
         I_CALL, I_PUSHQ: begin
            alu_a = C_MINUS_EIGHT;
            alu_b = valB;
         end
         I_RET, I_POPQ: begin
            alu_a = C_EIGHT;
            alu_b = valB;
         end
         default: begin
            alu_a = '0;
            alu_b = '0;
         end
      endcase
   end

   execute_stage_alu #(.W(W)) u_alu (
      .a_i   (alu_a),
      .b_i   (alu_b),
      .fn_i  (alu_fn),
      .res_o (alu_res),
      .of_o  (alu_of)
   );

   // Cnd looks at the CC as it stands before this edge's update.
   cond_eval u_cond (
      .ifun_i (ifun),
      .zf_i   (cc_q.zf),
      .sf_i   (cc_q.sf),
      .of_i   (cc_q.of),
      .cnd_o  (cnd)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      out_icode_d = out_icode_q;
      out_valE_d  = out_valE_q;
      out_valA_d  = out_valA_q;
      out_cnd_d   = out_cnd_q;
      out_err_d   = out_err_q;
      cc_d        = cc_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         out_icode_d = icode;
         out_valE_d  = alu_res;
         out_valA_d  = valA;
         out_cnd_d   = ((icode == I_RRMOVQ) || (icode == I_JXX)) ? cnd : 1'b0;
         out_err_d   = is_opq && !ifun_ok;
         if (is_opq && ifun_ok && set_cc) begin
            cc_d.zf = (alu_res == '0);
            cc_d.sf = alu_res[W-1];
            cc_d.of = alu_of;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_icode_q <= '0;
         out_valE_q  <= '0;
         out_valA_q  <= '0;
         out_cnd_q   <= 1'b0;
         out_err_q   <= 1'b0;
         cc_q        <= CC_RESET;
      end else begin
         out_valid_q <= out_valid_d;
         out_icode_q <= out_icode_d;
         out_valE_q  <= out_valE_d;
         out_valA_q  <= out_valA_d;
         out_cnd_q   <= out_cnd_d;
         out_err_q   <= out_err_d;
         cc_q        <= cc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_icode = out_icode_q;
   assign out_valE  = out_valE_q;
   assign out_valA  = out_valA_q;
   assign out_cnd   = out_cnd_q;
   assign out_err   = out_err_q;
   assign cc_zf     = cc_q.zf;
   assign cc_sf     = cc_q.sf;
   assign cc_of     = cc_q.of;

endmodule

`default_nettype wire

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y86-64 execute stage: the initiator/consumer side of the team's 64-bit Add/Sub/And/Xor units.
- Accepts decoded operands over a valid/ready handshake and selects ALU inputs and function per icode/ifun.
- Registers valE, maintains the condition-code register (ZF/SF/OF) and evaluates Cnd for jXX/cmovXX.
- Sits between decode and memory stages.

Parameters:
- W, 64, datapath width (only 64 is supported).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- icode  in  4  Y86 instruction code.
- ifun  in  4  function / condition code.
- valA  in  64  operand A.
- valB  in  64  operand B.
- valC  in  64  immediate / displacement.
- set_cc  in  1  CC update permitted (low when a younger stage holds an exception).
- flush  in  1  squash the held result and the incoming instruction.
- out_valid  out  1  result register valid.
- out_ready  in  1  memory stage consumes the result.
- out_icode  out  4  registered icode.
- out_valE  out  64  registered ALU result.
- out_valA  out  64  registered valA, passed through.
- out_cnd  out  1  registered condition result.
- out_err  out  1  invalid ifun for OPq.
- cc_zf / cc_sf / cc_of  out  1 each  architectural condition codes.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; out_icode=0; out_valE=0; out_valA=0; out_cnd=0; out_err=0.
  - CC: ZF=1, SF=0, OF=0.
- Handshake:
  - in_ready = !out_valid | out_ready (single-entry output register).
  - Accept = in_valid & in_ready & !flush.
  - Latency is 1 cycle: the result appears on the cycle after accept.
  - Output fields hold stable while out_valid & !out_ready.
- On accept, output register loads and out_valid=1.
- If out_ready and no accept, out_valid=0.
- flush: out_valid clears next edge; no CC update; flush overrides a simultaneous accept.
- valE by icode:
  - 0 halt, 1 nop, 7 jXX: 0.
  - 2 rrmovq/cmovXX: valA + 0.
  - 3 irmovq: valC.
  - 4 rmmovq, 5 mrmovq: valB + valC.
  - 6 OPq, by ifun: 0 valB+valA; 1 valB−valA; 2 valB&valA; 3 valB^valA.
  - 8 call, A pushq: valB − 8.
  - 9 ret, B popq: valB + 8.
  - Other icodes: valE=0.
- Arithmetic is two's complement mod 2^64; wrap-around is silent.
- OPq with ifun > 3: valE=0, out_err=1, no CC update.
- Flags (OPq only):
  - ZF = (valE==0); SF = valE[63].
  - OF for add: sign(valA)==sign(valB) and sign(valE)!=sign(valB).
  - OF for sub: sign(valA)!=sign(valB) and sign(valE)!=sign(valB).
  - OF for and/xor: 0.
- CC write: on accept when icode==6 & set_cc & ifun valid; written at the same edge as the output register.
- Cnd:
  - Computed from CC before that edge, i.e. the value left by the previous OPq.
  - Conditions by ifun: 0 always; 1 le=(SF^OF)|ZF; 2 l=SF^OF; 3 e=ZF; 4 ne=~ZF; 5 ge=~(SF^OF); 6 g=~(SF^OF)&~ZF; ifun>6 gives 0.
  - out_cnd = Cnd for icode 2 or 7, else 0.
- Back-to-back OPq then cmov: the cmov sees the CC written by the OPq (which is already registered).
- Reset mid-stall drops the held result and restores reset CC.

Decomposition:
- Package y86_pkg holds:
  - icode constants (I_HALT..I_POPQ).
  - ALU ifun constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR).
  - Condition constants (C_ALWAYS..C_G).
  - Reset CC value.
- Sub-module cond_eval (combinational): inputs ifun, zf, sf, of; output cnd.
- The ALU datapath instantiates the existing Add, Sub, And, Xor units with an output mux; no new adder.

Test Plan:
- Reset, then OPq add valA=1, valB=2, set_cc=1, out_ready=1 -> next cycle out_valE=3; ZF=0, SF=0, OF=0; out_valid=1.
- OPq add valA=valB=0x7FFF_FFFF_FFFF_FFFF -> out_valE=0xFFFF_FFFF_FFFF_FFFE; SF=1, OF=1. Then cmovl (2/3) -> out_cnd=0 because SF^OF=0; then cmovle (2/1) -> out_cnd=0.
- OPq sub valA=5, valB=5 -> valE=0, ZF=1. Next jXX je (7/3) -> out_cnd=1; jne -> 0.
- out_ready=0 held 3 cycles with in_valid=1 -> in_ready=0, outputs stable, CC unchanged; release -> next instruction accepted the same cycle out_ready=1.
- flush asserted together with an OPq accept -> out_valid=0 next cycle, CC unchanged. Separately, OPq with set_cc=0 -> valE correct, CC unchanged.
- pushq valB=0x100 -> valE=0xF8. popq valB=0x100 -> 0x108. OPq ifun=7 -> out_err=1, valE=0, CC unchanged. Assert rst_n mid-stall -> out_valid=0, ZF=1.
